// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants and Gray/binary helpers, used by both pointer domains.
// Pure combinational helpers; no state, no flow control.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int PTR_W           = FIFO_ADDR_WIDTH + 1;

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] gray);
        logic [PTR_W-1:0] bin;
        for (int i = 0; i < PTR_W; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/r_ptr_empty_check_gray2bin_conv.sv
// Gray-to-binary converter: each binary bit is the XOR of the Gray bits at and above it.
// Purely combinational, zero latency; no flow control.
module gray2bin_conv #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    always_comb begin
        o_bin = '0;
        for (int i = 0; i < W; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/r_ptr_empty_check.sv
// Async-FIFO read-side pointer/status: Gray read pointer, empty, fill count, underflow.
// All status registered, one r_clk edge after inputs; reads while empty are dropped and flagged.
module r_ptr_empty_check
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH      = FIFO_ADDR_WIDTH,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                  r_clk,
    input  logic                  r_reset,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    input  logic                  r_inc,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   r_ptr,
    output logic                  r_empty,
    output logic                  r_almost_empty,
    output logic [ADDR_WIDTH:0]   r_count,
    output logic                  r_valid,
    output logic                  r_underflow
);

    localparam int            PW    = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

    logic [PW-1:0] r_bin_ptr;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_wbin;
    logic [PW-1:0] w_count_next;
    logic          w_rd_ok;

    gray2bin_conv #(.W(PW)) u_wptr_g2b (
        .i_gray (rq2_wptr),
        .o_bin  (w_wbin)
    );

    assign w_rd_ok      = r_inc & ~r_empty;
    assign w_bin_next   = r_bin_ptr + {{(PW-1){1'b0}}, w_rd_ok};
    assign w_gray_next  = w_bin_next ^ (w_bin_next >> 1);
    // Synchronised write pointer lags, so this difference can only under-count.
    assign w_count_next = w_wbin - w_bin_next;
    assign r_addr       = r_bin_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge r_clk) begin
        if (!r_reset) begin
            r_bin_ptr      <= '0;
            r_ptr          <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_count        <= '0;
            r_valid        <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_bin_ptr      <= w_bin_next;
            r_ptr          <= w_gray_next;
            r_empty        <= (w_gray_next == rq2_wptr);
            r_almost_empty <= (w_count_next <= AE_TH);
            r_count        <= w_count_next;
            r_valid        <= w_rd_ok;
            r_underflow    <= r_underflow | (r_inc & r_empty);
        end
    end

endmodule

// File: tb/tb_r_ptr_empty_check.sv
// Directed bench for r_ptr_empty_check with a queue of expected register states.
module tb_r_ptr_empty_check;

    logic       r_clk = 1'b0;
    logic       r_reset = 1'b0;
    logic [4:0] rq2_wptr = '0;
    logic       r_inc = 1'b0;
    logic [3:0] r_addr;
    logic [4:0] r_ptr;
    logic       r_empty;
    logic       r_almost_empty;
    logic [4:0] r_count;
    logic       r_valid;
    logic       r_underflow;

    r_ptr_empty_check #(.ADDR_WIDTH(4), .ALMOST_EMPTY_TH(1)) dut (
        .r_clk          (r_clk),
        .r_reset        (r_reset),
        .rq2_wptr       (rq2_wptr),
        .r_inc          (r_inc),
        .r_addr         (r_addr),
        .r_ptr          (r_ptr),
        .r_empty        (r_empty),
        .r_almost_empty (r_almost_empty),
        .r_count        (r_count),
        .r_valid        (r_valid),
        .r_underflow    (r_underflow)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic [4:0] ptr;
        logic [3:0] addr;
        logic       empty;
        logic       ae;
        logic [4:0] count;
        logic       valid;
        logic       uf;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference state: plain integer read/write totals modulo 32.
    int   m_rd = 0;
    int   m_wr = 0;
    logic m_empty = 1'b1;
    logic m_uf = 1'b0;

    function automatic logic [4:0] to_gray(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag, input exp_t e);
        chk({tag, ".r_ptr"},          32'(r_ptr),          32'(e.ptr));
        chk({tag, ".r_addr"},         32'(r_addr),         32'(e.addr));
        chk({tag, ".r_empty"},        32'(r_empty),        32'(e.empty));
        chk({tag, ".r_almost_empty"}, 32'(r_almost_empty), 32'(e.ae));
        chk({tag, ".r_count"},        32'(r_count),        32'(e.count));
        chk({tag, ".r_valid"},        32'(r_valid),        32'(e.valid));
        chk({tag, ".r_underflow"},    32'(r_underflow),    32'(e.uf));
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge state, then compare it.
    task automatic step(input string tag, input logic rst_n, input logic inc, input int wr);
        exp_t e;
        int   rd_n;
        int   cnt;
        logic ok;
        @(negedge r_clk);
        r_reset  = rst_n;
        r_inc    = inc;
        rq2_wptr = to_gray(wr);
        if (!rst_n) begin
            m_rd = 0; m_empty = 1'b1; m_uf = 1'b0;
            e = '{ptr: 5'd0, addr: 4'd0, empty: 1'b1, ae: 1'b1, count: 5'd0, valid: 1'b0, uf: 1'b0};
        end else begin
            ok   = inc & ~m_empty;
            rd_n = (m_rd + (ok ? 1 : 0)) % 32;
            cnt  = (((wr % 32) - rd_n) % 32 + 32) % 32;
            m_uf = m_uf | (inc & m_empty);
            m_empty = (rd_n == (wr % 32));
            m_rd = rd_n;
            e.ptr = to_gray(rd_n);
            e.addr = 4'(rd_n % 16);
            e.empty = m_empty;
            e.ae = (cnt <= 1);
            e.count = 5'(cnt);
            e.valid = ok;
            e.uf = m_uf;
        end
        m_wr = wr;
        q.push_back(e);
        @(posedge r_clk);
        #1;
        last = q.pop_front();
        check_state(tag, last);
    endtask

    initial begin
        // Reset held two edges with a read request pending.
        step("rst0", 1'b0, 1'b1, 0);
        step("rst1", 1'b0, 1'b1, 0);

        step("fill3", 1'b1, 1'b0, 3);
        chk("fill3.count_const", 32'(r_count), 32'd3);

        step("drain0", 1'b1, 1'b1, 3);
        chk("drain0.ptr_const", 32'(r_ptr), 32'h01);
        step("drain1", 1'b1, 1'b1, 3);
        chk("drain1.ptr_const", 32'(r_ptr), 32'h03);
        step("drain2", 1'b1, 1'b1, 3);
        chk("drain2.ptr_const", 32'(r_ptr), 32'h02);
        chk("drain2.empty_const", 32'(r_empty), 32'd1);

        step("uflow", 1'b1, 1'b1, 3);
        chk("uflow.ptr_const", 32'(r_ptr), 32'h02);
        chk("uflow.flag_const", 32'(r_underflow), 32'd1);
        step("uflow_hold0", 1'b1, 1'b0, 3);
        step("uflow_hold1", 1'b1, 1'b0, 3);
        step("uflow_clr", 1'b0, 1'b0, 0);

        // Full 16-entry pass across the address wrap, then a second pass back to zero.
        step("wrap_fill", 1'b1, 1'b0, 16);
        chk("wrap_fill.count_const", 32'(r_count), 32'd16);
        for (int i = 0; i < 16; i++) step("wrap_rd", 1'b1, 1'b1, 16);
        chk("wrap.ptr_const", 32'(r_ptr), 32'h18);
        chk("wrap.addr_const", 32'(r_addr), 32'd0);
        step("wrap_idle", 1'b1, 1'b1, 16);
        step("wrap2_fill", 1'b1, 1'b0, 32);
        for (int i = 0; i < 16; i++) step("wrap2_rd", 1'b1, 1'b1, 32);
        chk("wrap2.ptr_const", 32'(r_ptr), 32'h00);

        // Last read coincides with a write that only shows up one cycle later.
        step("sim_rst", 1'b0, 1'b0, 0);
        step("sim_fill", 1'b1, 1'b0, 1);
        step("sim_last", 1'b1, 1'b1, 1);
        step("sim_arrive", 1'b1, 1'b0, 2);
        chk("sim_arrive.empty_const", 32'(r_empty), 32'd0);

        // Random mix of reads and in-range write advances.
        for (int i = 0; i < 60; i++) begin
            int wr;
            wr = m_wr;
            if ($urandom_range(0, 1) == 1 && (((wr - m_rd) % 32 + 32) % 32) < 16) wr = (wr + 1) % 32;
            step("rand", 1'b1, 1'($urandom_range(0, 1)), wr);
        end

        // Reset while reading: outputs hold until the edge, then clear with no extra step.
        step("mid_rst0", 1'b0, 1'b0, 0);
        step("mid_fill", 1'b1, 1'b0, 5);
        step("mid_rd0", 1'b1, 1'b1, 5);
        step("mid_rd1", 1'b1, 1'b1, 5);
        @(negedge r_clk);
        r_reset = 1'b0;
        r_inc   = 1'b1;
        #1;
        check_state("mid_pre", last);
        step("mid_rst", 1'b0, 1'b1, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
